// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 width/sign codes, LSU state
// encoding and the store byte-lane helpers.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } lsu_state_e;

  // Byte enables for a store of width f3 at byte offset off within the word.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return 4'b0001 << off;
      F3_H:    return 4'b0011 << off;
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicating the datum across lanes lets the mask alone pick the target lane.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Core-side request/response bus of the load/store unit.
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        misaligned;
  logic        access_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, misaligned, access_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, misaligned, access_fault
  );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load alignment: picks the addressed byte/half out of a RAM
// word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = i_word[8*gi +: 8];
    end
  endgenerate

  assign w_byte = w_lane[i_off];
  assign w_half = i_off[1] ? {w_lane[3], w_lane[2]} : {w_lane[1], w_lane[0]};

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit in front of a byte-masked synchronous-read data RAM.
// Stores complete in the request cycle; a load holds the port for one extra cycle.
module lsu_mem_port
  import rv32i_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter bit RANGE_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_mem_port_if.slave     core,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_masking,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_next;
  logic [1:0]        r_off;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_word_addr;
  logic              r_misaligned;
  logic              r_access_fault;

  logic w_f3_illegal;
  logic w_range_fault;
  logic w_misaligned_req;
  logic w_accept;
  logic w_fault;
  logic w_misal;
  logic w_legal;
  logic w_load_go;

  always_comb begin
    w_f3_illegal = 1'b0;
    if (core.req_we)
      w_f3_illegal = !((core.req_funct3 == F3_B) || (core.req_funct3 == F3_H) ||
                       (core.req_funct3 == F3_W));
    else
      w_f3_illegal = (core.req_funct3 == 3'b011) || (core.req_funct3 == 3'b110) ||
                     (core.req_funct3 == 3'b111);
  end

  generate
    if (RANGE_CHECK) begin : g_range_check
      assign w_range_fault = |core.req_addr[31:ADDR_W+2];
    end else begin : g_no_range_check
      assign w_range_fault = 1'b0;
    end
  endgenerate

  // funct3[1:0] encodes the access width for both signed and unsigned loads.
  assign w_misaligned_req = ((core.req_funct3[1:0] == 2'b01) && core.req_addr[0]) ||
                            ((core.req_funct3[1:0] == 2'b10) && (core.req_addr[1:0] != 2'b00));

  assign w_accept  = rst_n && (r_state == IDLE) && core.req_valid;
  assign w_fault   = w_accept && (w_f3_illegal || w_range_fault);
  assign w_misal   = w_accept && !w_fault && w_misaligned_req;
  assign w_legal   = w_accept && !w_fault && !w_misaligned_req;
  assign w_load_go = w_legal && !core.req_we;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (w_load_go) w_state_next = LOAD_WAIT;
      LOAD_WAIT: w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  // Outputs are qualified by rst_n so a load dropped by reset never responds.
  always_comb begin
    core.req_ready = 1'b0;
    core.rsp_valid = 1'b0;
    mem_w_en       = 1'b0;
    mem_address    = core.req_addr[ADDR_W+1:2];
    mem_masking    = store_mask(core.req_funct3, core.req_addr[1:0]);
    case (r_state)
      IDLE: begin
        core.req_ready = rst_n;
        mem_w_en       = w_legal && core.req_we;
      end
      LOAD_WAIT: begin
        core.rsp_valid = rst_n;
        mem_address    = r_word_addr;
        mem_masking    = 4'b0000;
      end
      default: ;
    endcase
  end

  assign mem_write_data = store_lanes(core.req_funct3, core.req_wdata);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_off          <= 2'b00;
      r_f3           <= 3'b000;
      r_word_addr    <= '0;
      r_misaligned   <= 1'b0;
      r_access_fault <= 1'b0;
    end else begin
      r_misaligned   <= w_misal;
      r_access_fault <= w_fault;
      if (w_load_go) begin
        r_off       <= core.req_addr[1:0];
        r_f3        <= core.req_funct3;
        r_word_addr <= core.req_addr[ADDR_W+1:2];
      end
    end
  end

  assign core.misaligned   = r_misaligned;
  assign core.access_fault = r_access_fault;

  lsu_load_align u_load_align (
    .i_word   (mem_read_data),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_data   (core.rsp_data)
  );

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port with a behavioural 256x32 byte-masked RAM.
module tb_lsu_mem_port;
  import rv32i_pkg::*;

  localparam int K_STORE = 0;
  localparam int K_LOAD  = 1;
  localparam int K_MIS   = 2;
  localparam int K_FLT   = 3;
  localparam int K_NORSP = 4;

  typedef struct {
    logic [2:0]  kind;   // {access_fault, misaligned, rsp_valid}
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_w_en;
  logic [7:0]  mem_address;
  logic [3:0]  mem_masking;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [31:0] ram [256];

  exp_t        exp_q[$];
  int          n_err = 0;
  int          n_chk = 0;
  int          cyc   = 0;
  int          n_wen = 0;
  int          exp_wen = 0;
  logic [7:0]  last_load_waddr = 8'h00;

  always #5 clk = ~clk;

  lsu_mem_port_if bus ();

  lsu_mem_port #(.ADDR_W(8), .RANGE_CHECK(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .core           (bus),
    .mem_w_en       (mem_w_en),
    .mem_address    (mem_address),
    .mem_masking    (mem_masking),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      mem_read_data <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_w_en && mem_masking[b])
          ram[mem_address][8*b +: 8] <= mem_write_data[8*b +: 8];
      mem_read_data <= ram[mem_address];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (mem_w_en) n_wen++;
    if (bus.rsp_valid || bus.misaligned || bus.access_fault) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {29'b0, bus.access_fault, bus.misaligned, bus.rsp_valid}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", {29'b0, bus.access_fault, bus.misaligned, bus.rsp_valid}, {29'b0, e.kind});
        chk("pulse_cycle", cyc, e.cyc);
        if (e.kind == 3'b001) chk("rsp_data", bus.rsp_data, e.data);
      end
    end
  end

  task automatic issue(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input int kind,
                       input logic [3:0] xmask, input logic [31:0] xval, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    #1;
    while (!bus.req_ready && waited < 8) begin
      chk({name, "_hold_wen"}, {31'b0, mem_w_en}, 32'h0);
      chk({name, "_hold_addr"}, {24'b0, mem_address}, {24'b0, last_load_waddr});
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.req_ready) begin
      chk({name, "_ready_timeout"}, 32'h0, 32'h1);
      bus.req_valid = 1'b0;
      return;
    end
    chk({name, "_wen"}, {31'b0, mem_w_en}, (kind == K_STORE) ? 32'h1 : 32'h0);
    case (kind)
      K_STORE: begin
        chk({name, "_addr"}, {24'b0, mem_address}, {24'b0, addr[9:2]});
        chk({name, "_mask"}, {28'b0, mem_masking}, {28'b0, xmask});
        chk({name, "_wdata"}, mem_write_data, xval);
        exp_wen++;
      end
      K_LOAD: begin
        e.kind = 3'b001; e.data = xval; e.cyc = cyc + 1;
        exp_q.push_back(e);
        last_load_waddr = addr[9:2];
      end
      K_NORSP: last_load_waddr = addr[9:2];
      K_MIS: begin
        e.kind = 3'b010; e.data = 32'h0; e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
      default: begin
        e.kind = 3'b100; e.data = 32'h0; e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
    endcase
    $display("txn %s we=%0d f3=%03b addr=%08h wdata=%08h cyc=%0d", name, we, f3, addr, wdata, cyc);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    chk("rst_misaligned", {31'b0, bus.misaligned}, 32'h0);
    chk("rst_access_fault", {31'b0, bus.access_fault}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready", {31'b0, bus.req_ready}, 32'h1);

    issue("sw_10",  1'b1, F3_W,  32'h10, 32'hDEADBEEF, K_STORE, 4'b1111, 32'hDEADBEEF, w);
    issue("lw_10",  1'b0, F3_W,  32'h10, 32'h0,        K_LOAD,  4'h0,    32'hDEADBEEF, w);
    issue("sb_13",  1'b1, F3_B,  32'h13, 32'h00000080, K_STORE, 4'b1000, 32'h80808080, w);
    issue("lb_13",  1'b0, F3_B,  32'h13, 32'h0,        K_LOAD,  4'h0,    32'hFFFFFF80, w);
    issue("lbu_13", 1'b0, F3_BU, 32'h13, 32'h0,        K_LOAD,  4'h0,    32'h00000080, w);
    issue("lw_10b", 1'b0, F3_W,  32'h10, 32'h0,        K_LOAD,  4'h0,    32'h80ADBEEF, w);
    issue("lb_12",  1'b0, F3_B,  32'h12, 32'h0,        K_LOAD,  4'h0,    32'hFFFFFFAD, w);
    issue("sh_22",  1'b1, F3_H,  32'h22, 32'h12348001, K_STORE, 4'b1100, 32'h80018001, w);
    issue("lh_22",  1'b0, F3_H,  32'h22, 32'h0,        K_LOAD,  4'h0,    32'hFFFF8001, w);
    issue("lhu_22", 1'b0, F3_HU, 32'h22, 32'h0,        K_LOAD,  4'h0,    32'h00008001, w);
    issue("sw_30",  1'b1, F3_W,  32'h30, 32'h11223344, K_STORE, 4'b1111, 32'h11223344, w);
    issue("lb_31",  1'b0, F3_B,  32'h31, 32'h0,        K_LOAD,  4'h0,    32'h00000033, w);
    issue("lh_32",  1'b0, F3_H,  32'h32, 32'h0,        K_LOAD,  4'h0,    32'h00001122, w);
    issue("lbu_30", 1'b0, F3_BU, 32'h30, 32'h0,        K_LOAD,  4'h0,    32'h00000044, w);

    issue("lw_11_mis",   1'b0, F3_W,   32'h11,  32'h0,        K_MIS, 4'h0, 32'h0, w);
    issue("sw_400_flt",  1'b1, F3_W,   32'h400, 32'hFFFFFFFF, K_FLT, 4'h0, 32'h0, w);
    issue("lw_0",        1'b0, F3_W,   32'h0,   32'h0,        K_LOAD, 4'h0, 32'h0, w);
    issue("ld_f3_011",   1'b0, 3'b011, 32'h10,  32'h0,        K_FLT, 4'h0, 32'h0, w);
    issue("st_f3_100",   1'b1, 3'b100, 32'h10,  32'h55555555, K_FLT, 4'h0, 32'h0, w);
    issue("sh_21_mis",   1'b1, F3_H,   32'h21,  32'hFFFF,     K_MIS, 4'h0, 32'h0, w);
    issue("lhu_23_mis",  1'b0, F3_HU,  32'h23,  32'h0,        K_MIS, 4'h0, 32'h0, w);
    issue("lw_401_prio", 1'b0, F3_W,   32'h401, 32'h0,        K_FLT, 4'h0, 32'h0, w);
    issue("lw_10_chk",   1'b0, F3_W,   32'h10,  32'h0,        K_LOAD, 4'h0, 32'h80ADBEEF, w);

    issue("lw_30_a",   1'b0, F3_W,  32'h30, 32'h0, K_LOAD, 4'h0, 32'h11223344, w);
    issue("lbu_31_h",  1'b0, F3_BU, 32'h31, 32'h0, K_LOAD, 4'h0, 32'h00000033, w);
    chk("held_load_wait", w, 32'd1);
    issue("lw_30_b",   1'b0, F3_W,  32'h30, 32'h0,  K_LOAD,  4'h0,    32'h11223344, w);
    issue("sb_34_h",   1'b1, F3_B,  32'h34, 32'h5A, K_STORE, 4'b0001, 32'h5A5A5A5A, w);
    chk("held_store_wait", w, 32'd1);
    issue("lbu_34",    1'b0, F3_BU, 32'h34, 32'h0,  K_LOAD,  4'h0,    32'h0000005A, w);

    issue("sw_40",  1'b1, F3_W, 32'h40, 32'hA5A5A5A5, K_STORE, 4'b1111, 32'hA5A5A5A5, w);
    issue("sw_44",  1'b1, F3_W, 32'h44, 32'h0F0F0F0F, K_STORE, 4'b1111, 32'h0F0F0F0F, w);
    chk("b2b_store_wait", w, 32'd0);
    issue("lw_44",  1'b0, F3_W, 32'h44, 32'h0,        K_LOAD,  4'h0,    32'h0F0F0F0F, w);
    issue("lw_40",  1'b0, F3_W, 32'h40, 32'h0,        K_LOAD,  4'h0,    32'hA5A5A5A5, w);

    issue("lw_30_rst", 1'b0, F3_W, 32'h30, 32'h0, K_NORSP, 4'h0, 32'h0, w);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid_ready", {31'b0, bus.req_ready}, 32'h1);
    chk("rst_mid_rsp_after", {31'b0, bus.rsp_valid}, 32'h0);

    repeat (3) @(negedge clk);
    #3;
    chk("sb_drain", exp_q.size(), 32'd0);
    chk("wen_count", n_wen, exp_wen);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit between the RV32I execute stage and the byte-masked data RAM (256 x 32, synchronous read, per-byte write enables).
- Converts a core request (byte address, funct3, store data) into the RAM word address, 4-bit byte mask and lane-shifted write data.
- Captures the RAM read word one cycle later, extracts the addressed byte/half/word and sign- or zero-extends it.
- Detects misaligned and out-of-range accesses; allows one outstanding load.

Parameters:
- ADDR_W, 8, RAM word-address width; RAM depth is 2^ADDR_W words.
- RANGE_CHECK, 1, when 1, any nonzero addr[31:ADDR_W+2] raises access_fault; when 0 those bits are ignored.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  LSU accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  load result valid (one-cycle pulse).
- rsp_data  out  32  extended load result.
- misaligned  out  1  one-cycle pulse: request rejected, misaligned.
- access_fault  out  1  one-cycle pulse: out of range or illegal funct3.
- mem_w_en  out  1  to RAM w_en.
- mem_address  out  ADDR_W  to RAM address; equals req_addr[ADDR_W+1:2].
- mem_masking  out  4  to RAM byte mask.
- mem_write_data  out  32  to RAM write data, lane-shifted.
- mem_read_data  in  32  from RAM; valid the cycle after the address is presented.

Behaviour:
- Reset: synchronous on clk while rst_n=0. State goes to IDLE; rsp_valid, misaligned and access_fault are 0; registered offset and funct3 are cleared.
- Reset mid-load: an outstanding load is dropped and no rsp_valid is produced.
- Request legality:
  - Illegal funct3: 011, 110, 111 for loads; anything other than 000/001/010 for stores.
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Priority: access_fault over misaligned.
  - A faulting request causes no RAM write and no load response. The fault pulse is registered and appears in cycle N+1.
- States:
  - IDLE: req_ready=1.
    - Legal store in cycle N: mem_w_en=1 combinationally in N; RAM commits at the end of N. Stay IDLE; no rsp_valid.
    - Legal load in cycle N: mem_w_en=0; register funct3 and addr[1:0]; go to LOAD_WAIT.
  - LOAD_WAIT (cycle N+1): req_ready=0. rsp_valid=1 and rsp_data is formed from mem_read_data. Always return to IDLE next cycle.
  - Load-to-use latency: 1 cycle. Back-to-back loads are accepted every 2 cycles; stores every cycle.
- mem_address and the mask/data outputs follow req_addr combinationally in IDLE. In LOAD_WAIT, mem_address holds the loaded word address and mem_w_en=0.
- Store mask and data, with off = addr[1:0]:
  - SB: mask = 0001<<off; data = {4{wdata[7:0]}}.
  - SH: mask = 0011<<off; data = {2{wdata[15:0]}}.
  - SW: mask = 1111; data = wdata.
- Load extraction: byte = word[8*off +: 8]; half = word[16*off[1] +: 16]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- mem_w_en is 0 whenever req_valid=0, the request faults, or state is LOAD_WAIT.
- A request presented while req_ready=0 is ignored and must be held by the core.

Decomposition:
- Shared package (rv32i_pkg): funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and LSU state encodings (IDLE, LOAD_WAIT).
- One natural sub-module, lsu_load_align: purely combinational mem_read_data + offset + funct3 -> rsp_data, reusable for instruction-fetch alignment.
- Store lane/mask generation stays inline.

Test Plan:
- SW addr 0x0000_0010, wdata 0xDEADBEEF -> mem_w_en=1, mem_address=0x04, mask=1111, write_data=0xDEADBEEF. Then LW 0x10 -> rsp_valid next cycle, rsp_data=0xDEADBEEF.
- SB addr 0x13, wdata 0x0000_0080 -> mask=1000, write_data=0x80808080. Then:
  - LB 0x13 -> rsp_data=0xFFFFFF80.
  - LBU 0x13 -> 0x00000080.
  - LW 0x10 -> 0x80ADBEEF.
- SH addr 0x22, wdata 0x1234_8001 -> mask=1100. Then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001.
- LW 0x11 -> misaligned=1 in the next cycle, mem_w_en never 1, no rsp_valid. With RANGE_CHECK=1, SW 0x0000_0400 -> access_fault=1 and RAM unchanged.
- Load followed by a request held high in the next cycle -> req_ready=0 in LOAD_WAIT; second request accepted one cycle later; two rsp_valid pulses 2 cycles apart.
- Legal load accepted, rst_n=0 in the next cycle -> rsp_valid stays 0, state IDLE, req_ready=1 after rst_n releases.
